// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter
//   Shares one single-ported data memory between the pipeline MEM stage
//   (CPU port) and an external loader/debug port (EXT port). Each access is
//   sequenced through a req/ack handshake to a variable-latency backend.
//   The CPU is stalled while its access is outstanding. EXT is protected
//   against starvation by a saturating wait counter.
//
//   Optional feature: define DMEM_ARB_TIMEOUT_EN to abort a backend access
//   after TIMEOUT cycles without mem_ack_i (reads return 32'hDEADBEEF, and
//   err_o becomes sticky high). Without the macro the arbiter waits forever
//   and err_o is tied low.
//
// Ports
//   clk_i        rising-edge clock
//   start_i      asynchronous active-low reset
//   cpu_req_i    CPU access request            cpu_we_i     1 = write
//   cpu_addr_i   CPU address                   cpu_wdata_i  CPU write data
//   cpu_rdata_o  CPU read data (registered)    cpu_stall_o  pipeline stall
//   ext_req_i    EXT request                   ext_we_i     EXT write enable
//   ext_addr_i   EXT address                   ext_wdata_i  EXT write data
//   ext_done_o   one-cycle EXT completion      ext_rdata_o  EXT read data
//   mem_req_o    backend request               mem_we_o     backend write
//   mem_addr_o   backend address               mem_wdata_o  backend wdata
//   mem_rdata_i  backend read data             mem_ack_i    backend ack
//   err_o        sticky timeout error
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic          clk_i,
  input  logic          start_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [31:0]   cpu_wdata_i,
  output logic [31:0]   cpu_rdata_o,
  output logic          cpu_stall_o,
  input  logic          ext_req_i,
  input  logic          ext_we_i,
  input  logic [AW-1:0] ext_addr_i,
  input  logic [31:0]   ext_wdata_i,
  output logic          ext_done_o,
  output logic [31:0]   ext_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          err_o
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_CPU,
    BUSY_EXT,
    RESP_CPU,
    RESP_EXT
  } state_t;

  localparam int unsigned    WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]  WAIT_MAX = WW'(MAX_WAIT);

  state_t        state;
  logic [WW-1:0] wait_cnt;

  logic        wait_sat;
  logic        ext_win;
  logic        cpu_win;
  logic        ext_waiting;
  logic        busy;
  logic        timed_out;
  logic        finish;
  logic [31:0] resp_data;

  // With MAX_WAIT = 0 the counter is pinned at zero and wait_sat is always
  // true, so EXT wins every contested IDLE cycle.
  assign wait_sat    = (wait_cnt >= WAIT_MAX);
  assign ext_win     = ext_req_i && (wait_sat || !cpu_req_i);
  assign cpu_win     = cpu_req_i && !ext_win;
  assign ext_waiting = ext_req_i && (state != BUSY_EXT) && (state != RESP_EXT);
  assign busy        = (state == BUSY_CPU) || (state == BUSY_EXT);

  // Stall is gated by reset so every output reads 0 while start_i is low.
  assign cpu_stall_o = start_i && cpu_req_i && (state != RESP_CPU);

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;

  // A real ack in the last allowed cycle wins over the abort.
  assign timed_out = busy && !mem_ack_i && (tmo_cnt == TMO_LAST);
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timed_out      = 1'b0;
  assign err_o          = 1'b0;
`endif

  assign finish    = busy && (mem_ack_i || timed_out);
  assign resp_data = timed_out ? 32'hDEADBEEF : mem_rdata_i;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cpu_rdata_o <= '0;
      ext_rdata_o <= '0;
      ext_done_o  <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_o       <= 1'b0;
`endif
    end else begin
      ext_done_o <= 1'b0;

      // Grant clears the counter; otherwise count while EXT is kept waiting.
      if ((state == IDLE) && ext_win) begin
        wait_cnt <= '0;
      end else if (ext_waiting && !wait_sat) begin
        wait_cnt <= wait_cnt + WW'(1);
      end

`ifdef DMEM_ARB_TIMEOUT_EN
      if (busy && !mem_ack_i) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
      if (timed_out) begin
        err_o <= 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          if (ext_win) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= ext_we_i;
            mem_addr_o  <= ext_addr_i;
            mem_wdata_o <= ext_wdata_i;
            state       <= BUSY_EXT;
          end else if (cpu_win) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= cpu_we_i;
            mem_addr_o  <= cpu_addr_i;
            mem_wdata_o <= cpu_wdata_i;
            state       <= BUSY_CPU;
          end
        end

        BUSY_CPU: begin
          if (finish) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o) begin
              cpu_rdata_o <= resp_data;
            end
            state <= RESP_CPU;
          end
        end

        BUSY_EXT: begin
          if (finish) begin
            mem_req_o  <= 1'b0;
            ext_done_o <= 1'b1;
            if (!mem_we_o) begin
              ext_rdata_o <= resp_data;
            end
            state <= RESP_EXT;
          end
        end

        RESP_CPU: state <= IDLE;
        RESP_EXT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter (MAX_WAIT=4, TIMEOUT=8). A behavioural
//   backend answers mem_req_o after a programmable latency; expected read
//   data is queued per port when a request is issued and popped when the
//   DUT signals completion (RESP_CPU stall drop, or ext_done_o).
module tb_dmem_arbiter;

  logic        clk;
  logic        start_i;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        ext_req_i;
  logic        ext_we_i;
  logic [31:0] ext_addr_i;
  logic [31:0] ext_wdata_i;
  logic        ext_done_o;
  logic [31:0] ext_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        err_o;

  dmem_arbiter #(
    .AW       (32),
    .MAX_WAIT (4),
    .TIMEOUT  (8)
  ) dut (
    .clk_i       (clk),
    .start_i     (start_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .ext_req_i   (ext_req_i),
    .ext_we_i    (ext_we_i),
    .ext_addr_i  (ext_addr_i),
    .ext_wdata_i (ext_wdata_i),
    .ext_done_o  (ext_done_o),
    .ext_rdata_o (ext_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .err_o       (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors      = 0;
  int miscompares  = 0;
  int ack_lat      = 0;
  bit stray_ack    = 1'b0;
  int cpu_resp_cnt = 0;
  int ext_done_cnt = 0;
  int c0, e0, pc, pe, busy_n;

  logic [31:0] cpu_q[$];
  logic [31:0] ext_q[$];
  logic [31:0] exp_cpu_rd;
  logic [31:0] exp_ext_rd;
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] be_mem[logic [31:0]];

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  function automatic logic [31:0] be_read(input logic [31:0] a);
    return be_mem.exists(a) ? be_mem[a] : seed_word(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Backend: ack after ack_lat waiting cycles of mem_req_o; stray_ack injects
  // an ack with no request outstanding.
  initial begin
    int busy_cnt;
    busy_cnt    = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (stray_ack) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = '1;
      end else if (mem_req_o && start_i) begin
        if (busy_cnt >= ack_lat) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) be_mem[mem_addr_o] = mem_wdata_o;
          else          mem_rdata_i = be_read(mem_addr_o);
          busy_cnt = 0;
        end else begin
          busy_cnt++;
        end
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // One cycle; scoreboard pops on the completion events seen at this edge.
  task automatic tick();
    @(negedge clk);
    if (start_i && ext_done_o) begin
      ext_done_cnt++;
      check("ext_pending", 64'(ext_q.size() != 0), 64'(1));
      if (ext_q.size() != 0) check("ext_rdata", 64'(ext_rdata_o), 64'(ext_q.pop_front()));
    end
    if (start_i && cpu_req_i && !cpu_stall_o) begin
      cpu_resp_cnt++;
      check("cpu_pending", 64'(cpu_q.size() != 0), 64'(1));
      if (cpu_q.size() != 0) check("cpu_rdata", 64'(cpu_rdata_o), 64'(cpu_q.pop_front()));
    end
  endtask

  task automatic cpu_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    cpu_req_i   = 1'b1;
    if (we) ref_mem[addr] = wdata;
    else    exp_cpu_rd = ref_read(addr);
    cpu_q.push_back(exp_cpu_rd);
  endtask

  task automatic ext_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    ext_we_i    = we;
    ext_addr_i  = addr;
    ext_wdata_i = wdata;
    ext_req_i   = 1'b1;
    if (we) ref_mem[addr] = wdata;
    else    exp_ext_rd = ref_read(addr);
    ext_q.push_back(exp_ext_rd);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_rdata"}, 64'(cpu_rdata_o), 64'(0));
    check({tag, "_stall"},     64'(cpu_stall_o), 64'(0));
    check({tag, "_ext_done"},  64'(ext_done_o),  64'(0));
    check({tag, "_ext_rdata"}, 64'(ext_rdata_o), 64'(0));
    check({tag, "_mem_req"},   64'(mem_req_o),   64'(0));
    check({tag, "_mem_we"},    64'(mem_we_o),    64'(0));
    check({tag, "_mem_addr"},  64'(mem_addr_o),  64'(0));
    check({tag, "_mem_wdata"}, 64'(mem_wdata_o), 64'(0));
    check({tag, "_err"},       64'(err_o),       64'(0));
  endtask

  // Uncontested CPU access: stall spans IDLE + (lat+1) BUSY cycles.
  task automatic cpu_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat);
    int stalls;
    int n0;
    bit done;
    ack_lat = lat;
    cpu_issue(we, addr, wdata);
    #1;
    check({tag, "_stall_idle"}, 64'(cpu_stall_o), 64'(1));
    stalls = 1;
    n0     = cpu_resp_cnt;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (cpu_resp_cnt != n0) begin
        done = 1'b1;
      end else begin
        stalls++;
        check({tag, "_mem_req"},  64'(mem_req_o),  64'(1));
        check({tag, "_mem_we"},   64'(mem_we_o),   64'(we));
        check({tag, "_mem_addr"}, 64'(mem_addr_o), 64'(addr));
        if (we) check({tag, "_mem_wdata"}, 64'(mem_wdata_o), 64'(wdata));
      end
    end
    check({tag, "_resp_seen"}, 64'(done), 64'(1));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(lat + 2));
    cpu_req_i = 1'b0;
    tick();
  endtask

  // Uncontested EXT access: one done pulse, CPU never stalled.
  task automatic ext_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat);
    int n0;
    bit done;
    ack_lat = lat;
    ext_issue(we, addr, wdata);
    n0   = ext_done_cnt;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      check({tag, "_stall"}, 64'(cpu_stall_o), 64'(0));
      if (ext_done_cnt != n0) done = 1'b1;
      else check({tag, "_mem_addr"}, 64'(mem_addr_o), 64'(addr));
    end
    check({tag, "_done_seen"}, 64'(done), 64'(1));
    ext_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check({tag, "_done_low"}, 64'(ext_done_o), 64'(0));
    end
    check({tag, "_done_pulses"}, 64'(ext_done_cnt - n0), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    start_i     = 1'b0;
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    ext_req_i   = 1'b0;
    ext_we_i    = 1'b0;
    ext_addr_i  = '0;
    ext_wdata_i = '0;
    exp_cpu_rd  = '0;
    exp_ext_rd  = '0;
    ref_mem[32'h10] = 32'h12345678;
    be_mem[32'h10]  = 32'h12345678;
    ref_mem[32'h40] = 32'hCAFEF00D;
    be_mem[32'h40]  = 32'hCAFEF00D;

    // Reset: every output low even with cpu_req_i asserted.
    #12;
    check_all_zero("rst");
    cpu_req_i = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    tick();

    // CPU read, ack one cycle after request: 3 stall cycles.
    cpu_txn("cpu_rd", 1'b0, 32'h10, 32'h0, 1);
    // CPU write: mem_* held through the wait, cpu_rdata unchanged.
    cpu_txn("cpu_wr", 1'b1, 32'h20, 32'hA5A5A5A5, 2);
    cpu_txn("cpu_rdback", 1'b0, 32'h20, 32'h0, 0);

    // EXT read with CPU idle.
    ext_txn("ext_rd", 1'b0, 32'h40, 32'h0, 0);

    // Starvation: CPU streams 6 reads, EXT requests twice. Each EXT grant
    // needs wait_cnt to climb from 0 to 4 (two CPU accesses first).
    ack_lat = 0;
    c0 = cpu_resp_cnt;
    e0 = ext_done_cnt;
    cpu_issue(1'b0, 32'h80, 32'h0);
    ext_issue(1'b0, 32'h44, 32'h0);
    for (int i = 0; i < 60 && ((cpu_resp_cnt - c0) < 6 || (ext_done_cnt - e0) < 2); i++) begin
      pc = cpu_resp_cnt;
      pe = ext_done_cnt;
      tick();
      if (ext_done_cnt != pe) begin
        if ((ext_done_cnt - e0) == 1) begin
          check("starve_cpu_before_ext1", 64'(cpu_resp_cnt - c0), 64'(2));
          ext_issue(1'b0, 32'h48, 32'h0);
        end else begin
          check("starve_cpu_before_ext2", 64'(cpu_resp_cnt - c0), 64'(4));
          ext_req_i = 1'b0;
        end
      end
      if (cpu_resp_cnt != pc) begin
        if ((cpu_resp_cnt - c0) < 6) cpu_issue(1'b0, 32'h80 + 32'(4 * (cpu_resp_cnt - c0)), 32'h0);
        else                         cpu_req_i = 1'b0;
      end
    end
    check("starve_cpu_count", 64'(cpu_resp_cnt - c0), 64'(6));
    check("starve_ext_count", 64'(ext_done_cnt - e0), 64'(2));
    check("starve_q_empty", 64'(cpu_q.size() + ext_q.size()), 64'(0));
    cpu_req_i = 1'b0;
    ext_req_i = 1'b0;
    tick();

    // Reset in the middle of a CPU access.
    ack_lat = 1000;
    cpu_issue(1'b0, 32'h10, 32'h0);
    tick();
    tick();
    check("rstbusy_mem_req", 64'(mem_req_o), 64'(1));
    start_i = 1'b0;
    #1;
    check_all_zero("rstbusy");
    cpu_q.delete();
    exp_cpu_rd = '0;
    exp_ext_rd = '0;
    tick();
    start_i   = 1'b1;
    cpu_req_i = 1'b0;
    ack_lat   = 0;
    e0 = ext_done_cnt;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstbusy_no_req", 64'(mem_req_o), 64'(0));
      check("rstbusy_no_done", 64'(ext_done_o), 64'(0));
    end
    check("rstbusy_done_cnt", 64'(ext_done_cnt - e0), 64'(0));

    // Stray ack in IDLE is ignored.
    @(posedge clk);
    stray_ack = 1'b1;
    @(posedge clk);
    stray_ack = 1'b0;
    tick();
    check("stray_mem_req", 64'(mem_req_o), 64'(0));
    check("stray_ext_done", 64'(ext_done_o), 64'(0));
    check("stray_cpu_rdata", 64'(cpu_rdata_o), 64'(0));
    check("stray_ext_rdata", 64'(ext_rdata_o), 64'(0));
    cpu_txn("post_stray", 1'b0, 32'h30, 32'h0, 0);

`ifdef DMEM_ARB_TIMEOUT_EN
    // Backend never answers: abort after 8 BUSY cycles.
    ack_lat     = 100000;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h50;
    cpu_req_i   = 1'b1;
    exp_cpu_rd  = 32'hDEADBEEF;
    cpu_q.push_back(exp_cpu_rd);
    busy_n = 0;
    c0     = cpu_resp_cnt;
    for (int i = 0; i < 40 && cpu_resp_cnt == c0; i++) begin
      tick();
      if (cpu_resp_cnt == c0 && mem_req_o) busy_n++;
    end
    check("tmo_busy_cycles", 64'(busy_n), 64'(8));
    check("tmo_err", 64'(err_o), 64'(1));
    check("tmo_mem_req_low", 64'(mem_req_o), 64'(0));
    cpu_req_i = 1'b0;
    ack_lat   = 0;
    @(posedge clk);
    stray_ack = 1'b1;
    @(posedge clk);
    stray_ack = 1'b0;
    tick();
    check("tmo_late_ack_rdata", 64'(cpu_rdata_o), 64'(32'hDEADBEEF));
    check("tmo_err_sticky", 64'(err_o), 64'(1));
    ext_txn("tmo_ext", 1'b0, 32'h40, 32'h0, 1);
    check("tmo_err_sticky2", 64'(err_o), 64'(1));
`else
    check("err_tied", 64'(err_o), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
